conv1d_stream_layer: RTL
========================

# conv1d_stream_layer

Parametrised 1-D convolution layer with a runtime-loadable filter. It is the next generation of the fixed-ROM `layerN_*` blocks. Coefficients arrive over their own valid/ready stream instead of a compiled-in ROM, and the filter is kept across input vectors. P parallel MAC lanes compute output groups, with a saturating output stage and optional ReLU. The block sits between an upstream vector producer and a downstream layer, using the same s_/m_ handshake as the existing layers.

## Interface
- WIDTH, 16: signed data/coefficient width.
- LENX, 32: input vector length.
- LENF, 9: filter length; must satisfy LENF ≤ LENX.
- P, 3: number of parallel MAC lanes; must satisfy 1 ≤ P ≤ LENX-LENF+1.
- SIZE, LENX-LENF+1: output vector length (derived, not overridden).
- ADDRX, $clog2(LENX): x address width (derived).
- ADDRF, $clog2(LENF): f address width (derived).
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- s_data_in_f  in  WIDTH  filter coefficient, signed.
- s_valid_f  in  1  coefficient valid.
- s_ready_f  out  1  block accepts coefficient.
- s_data_in_x  in  WIDTH  input sample, signed.
- s_valid_x  in  1  sample valid.
- s_ready_x  out  1  block accepts sample.
- m_data_out_y  out  WIDTH  output sample, signed.
- m_valid_y  out  1  output valid.
- m_ready_y  in  1  downstream accepts output.

## Operation
- Handshake: a transfer occurs on a cycle where valid && ready. Producers may not retract valid before the transfer.
- States and transitions:
  - LOAD_F → LOAD_X after LENF f transfers.
  - LOAD_X → COMPUTE after LENX x transfers.
  - COMPUTE → DRAIN when the group result is registered.
  - DRAIN → COMPUTE (next group) or → LOAD_X (after output SIZE-1).
  - Reset enters LOAD_F.
- Handshake ready per state:
  - s_ready_f = 1 only in LOAD_F.
  - s_ready_x = 1 only in LOAD_X.
  - x stream is ignored in LOAD_F even if s_valid_x is high.
- Filter storage: f[i] is stored in arrival order and retained for every following vector until reset. No reload without reset.
- Input storage: x[i] is stored in arrival order. Each lane has its own read port, so there is one x memory copy per lane.
- Group g covers outputs k = g·P + j, for j = 0..P-1.
- Per-lane arithmetic:
  - Lane j accumulates y[k] = Σ_{i=0}^{LENF-1} x[k+i]·f[i].
  - Products are 2·WIDTH signed.
  - Accumulator is 2·WIDTH+ADDRF signed; it cannot overflow.
  - The accumulator is cleared at group start.
- Output stage: the accumulator is saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1]. There is no shift or rounding.
- Partial last group: lanes with k ≥ SIZE still run but their results are discarded. DRAIN emits only outputs k < SIZE.
- DRAIN ordering: results are emitted in ascending k, one per m_ready_y handshake.
- Backpressure: while m_valid_y=1 && m_ready_y=0, m_data_out_y holds stable.

## Timing
- Reset values:
  - s_ready_f = 1 (LOAD_F).
  - s_ready_x = 0.
  - m_valid_y = 0.
  - m_data_out_y = 0.
  - All counters = 0.
- Memory read latency is 1 cycle. The MAC register adds 1 cycle.
- Group latency: COMPUTE lasts exactly LENF+2 cycles. m_valid_y rises on the cycle after COMPUTE ends.
  - If the last x transfer is at cycle T, the first m_valid_y is at T+LENF+3.
- Next group: the next COMPUTE starts the cycle after the last DRAIN transfer of the current group. There is no overlap of compute and drain.
- Return to LOAD_X: after the final output transfer, s_ready_x = 1 on the next cycle.
- Minimum spacing between back-to-back vectors: LENX + ceil(SIZE/P)·(LENF+2) + SIZE cycles.
- Reset mid-operation (any state): all outputs return to their reset values immediately. Partial data and the filter are discarded.

## Configuration
- RELU_EN defined: any negative result is replaced by 0. The ReLU is applied after saturation, in the same output register stage, so it adds no latency.
- RELU_EN undefined: signed saturated results pass through unchanged.

## Structure
- Package conv1d_pkg holds:
  - the state enum (LOAD_F, LOAD_X, COMPUTE, DRAIN);
  - an accumulator-width function acc_w(WIDTH, LENF);
  - a saturate function sat(acc, WIDTH).
- Sub-module conv1d_mac_lane is instantiated P times by generate. It contains the per-lane multiply, accumulate, clear/enable and saturation.
- The top level holds the FSM, the address counters, the memories and the output mux.

## Test plan
- Basic: f = all 1, x = 1..32 → 24 outputs y[k] = 9k+45, i.e. 45, 54, …, 252, in order, with m_ready_y tied to 1.
- Saturation: f = all 32767, x = all 32767 → every y = 32767. With f = all -32768 and x = all 32767 → every y = -32768, or 0 when RELU_EN is defined.
- Backpressure: random m_ready_y at 30% duty → m_data_out_y stable while stalled, and the sequence matches the basic case exactly.
- Partial group: P=5 → exactly 24 outputs, then s_ready_x = 1 next cycle.
- Filter reuse: second vector x = 32..1 with no f reload → y[k] = 252-9k, i.e. 252, …, 45.
- Reset mid-operation: assert reset during DRAIN after 5 outputs → m_valid_y = 0 and s_ready_f = 1 immediately. After reloading the filter, the basic case reproduces correctly.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the streaming 1-D convolution layer:
// FSM state encoding, accumulator sizing and output saturation.
package conv1d_pkg;

  typedef enum logic [1:0] {
    LOAD_F  = 2'd0,
    LOAD_X  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Saturation works on a fixed wide container so one function serves any lane width.
  localparam int SAT_W = 64;

  // Sum of LENF full-precision products needs clog2(LENF) guard bits (at least one).
  function automatic int acc_w(input int width, input int lenf);
    int guard;
    guard = $clog2(lenf);
    if (guard < 1) guard = 1;
    return 2 * width + guard;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] acc,
                                                  input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/conv1d_mac_lane.sv
// One MAC lane: signed multiply, clearable accumulator and saturating output register.
// With RELU_EN defined, negative saturated results are replaced by zero in the same register.
module conv1d_mac_lane
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENF  = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    ld,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] f_in,
  output logic signed [WIDTH-1:0] res_out
);

  localparam int ACC_W = acc_w(WIDTH, LENF);

  logic signed [2*WIDTH-1:0] x_ext;
  logic signed [2*WIDTH-1:0] f_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [SAT_W-1:0]   acc_ext;
  logic signed [SAT_W-1:0]   acc_sat;
  logic signed [WIDTH-1:0]   res_d;
  logic signed [WIDTH-1:0]   res_q;

  always_comb begin
    x_ext   = {{WIDTH{x_in[WIDTH-1]}}, x_in};
    f_ext   = {{WIDTH{f_in[WIDTH-1]}}, f_in};
    prod    = x_ext * f_ext;
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end
    acc_ext = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    acc_sat = sat(acc_ext, WIDTH);
    res_d   = res_q;
    if (ld) begin
      res_d = acc_sat[WIDTH-1:0];
`ifdef RELU_EN
      if (acc_sat[SAT_W-1]) res_d = '0;
`endif
    end
  end

  // ---- accumulate stage / output register stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_out = res_q;

endmodule

// File: rtl/conv1d_stream_layer.sv
// Streaming 1-D convolution layer: runtime-loaded filter, P parallel MAC lanes,
// saturating output, optional ReLU when RELU_EN is defined.
module conv1d_stream_layer
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LENX  = 32,
  parameter int LENF  = 9,
  parameter int P     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y
);

  localparam int SIZE  = LENX - LENF + 1;
  localparam int ADDRX = $clog2(LENX);
  localparam int ADDRF = $clog2(LENF);
  localparam int FA    = (ADDRF < 1) ? 1 : ADDRF;
  localparam int XA    = (ADDRX < 1) ? 1 : ADDRX;
  // Lane addresses of a partial last group run past the vector end; two spare bits cover that.
  localparam int KA    = XA + 2;
  localparam int CW    = $clog2(LENF + 2);
  localparam int PW    = (P > 1) ? $clog2(P) : 1;

  state_e         state_q, state_d;
  logic [FA-1:0]  f_cnt_q, f_cnt_d;
  logic [XA-1:0]  x_cnt_q, x_cnt_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [KA-1:0]  k0_q, k0_d;
  logic [PW-1:0]  dj_q, dj_d;
  logic           rd_vld_p1_q, rd_vld_p1_d;

  logic           f_fire, x_fire, y_fire;
  logic           rd_act, last_cyc, lane_clr;
  logic [KA-1:0]  k_cur;

  logic signed [WIDTH-1:0]    f_mem [LENF];
  logic signed [WIDTH-1:0]    f_rd_p1_q;
  logic [P-1:0][WIDTH-1:0]    lane_res;

  assign s_ready_f = (state_q == LOAD_F);
  assign s_ready_x = (state_q == LOAD_X);
  assign m_valid_y = (state_q == DRAIN);

  assign f_fire   = s_valid_f && s_ready_f;
  assign x_fire   = s_valid_x && s_ready_x;
  assign y_fire   = m_valid_y && m_ready_y;
  assign rd_act   = (state_q == COMPUTE) && (cyc_q < CW'(LENF));
  assign last_cyc = (state_q == COMPUTE) && (cyc_q == CW'(LENF + 1));
  assign lane_clr = (state_q == COMPUTE) && (cyc_q == '0);
  assign k_cur    = k0_q + KA'(dj_q);

  always_comb begin
    state_d     = state_q;
    f_cnt_d     = f_cnt_q;
    x_cnt_d     = x_cnt_q;
    cyc_d       = cyc_q;
    k0_d        = k0_q;
    dj_d        = dj_q;
    rd_vld_p1_d = rd_act;
    case (state_q)
      LOAD_F: begin
        if (f_fire) begin
          if (f_cnt_q == FA'(LENF - 1)) begin
            f_cnt_d = '0;
            state_d = LOAD_X;
          end else begin
            f_cnt_d = f_cnt_q + FA'(1);
          end
        end
      end
      LOAD_X: begin
        if (x_fire) begin
          if (x_cnt_q == XA'(LENX - 1)) begin
            x_cnt_d = '0;
            cyc_d   = '0;
            k0_d    = '0;
            state_d = COMPUTE;
          end else begin
            x_cnt_d = x_cnt_q + XA'(1);
          end
        end
      end
      COMPUTE: begin
        if (last_cyc) begin
          cyc_d   = '0;
          dj_d    = '0;
          state_d = DRAIN;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DRAIN: begin
        // Lanes past the last valid output are never presented.
        if (y_fire) begin
          if (k_cur == KA'(SIZE - 1)) begin
            k0_d    = '0;
            dj_d    = '0;
            state_d = LOAD_X;
          end else if (dj_q == PW'(P - 1)) begin
            k0_d    = k0_q + KA'(P);
            dj_d    = '0;
            cyc_d   = '0;
            state_d = COMPUTE;
          end else begin
            dj_d = dj_q + PW'(1);
          end
        end
      end
      default: state_d = LOAD_F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD_F;
      f_cnt_q     <= '0;
      x_cnt_q     <= '0;
      cyc_q       <= '0;
      k0_q        <= '0;
      dj_q        <= '0;
      rd_vld_p1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_cnt_q     <= f_cnt_d;
      x_cnt_q     <= x_cnt_d;
      cyc_q       <= cyc_d;
      k0_q        <= k0_d;
      dj_q        <= dj_d;
      rd_vld_p1_q <= rd_vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (f_fire) f_mem[f_cnt_q] <= s_data_in_f;
  end

  // ---- memory read stage (p1): one filter tap shared by all lanes ----
  always_ff @(posedge clk) begin
    if (rd_act) f_rd_p1_q <= f_mem[cyc_q[FA-1:0]];
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    logic signed [WIDTH-1:0] x_mem [LENX];
    logic signed [WIDTH-1:0] x_rd_p1_q;
    logic signed [WIDTH-1:0] res;
    logic [KA-1:0]           x_addr;

    assign x_addr = k0_q + KA'(j) + KA'(cyc_q);

    always_ff @(posedge clk) begin
      if (x_fire) x_mem[x_cnt_q] <= s_data_in_x;
    end

    always_ff @(posedge clk) begin
      if (rd_act) x_rd_p1_q <= (x_addr < KA'(LENX)) ? x_mem[x_addr[XA-1:0]] : '0;
    end

    conv1d_mac_lane #(
      .WIDTH (WIDTH),
      .LENF  (LENF)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr     (lane_clr),
      .en      (rd_vld_p1_q),
      .ld      (last_cyc),
      .x_in    (x_rd_p1_q),
      .f_in    (f_rd_p1_q),
      .res_out (res)
    );

    assign lane_res[j] = res;
  end

  assign m_data_out_y = m_valid_y ? lane_res[dj_q] : '0;

endmodule
